// File: rtl/bilinear_scaler_seq.sv
`default_nettype none
// ============================================================================
// Module   : bilinear_scaler_seq
// Purpose  : Sequential bilinear image resizer. Reads four neighbours per
//            destination pixel from a 1-cycle-latency source BRAM, blends
//            them with fixed-point weights and writes one rounded pixel,
//            honouring sink backpressure. Run-time sizes and scale.
// Revision : 1.0 - initial release
// ============================================================================
module bilinear_scaler_seq #(
  parameter int ADDR_W = 19,
  parameter int PIX_W  = 8,
  parameter int DIM_W  = 16,
  parameter int FRAC_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DIM_W-1:0]  in_w,
  input  logic [DIM_W-1:0]  in_h,
  input  logic [DIM_W-1:0]  out_w,
  input  logic [DIM_W-1:0]  out_h,
  input  logic [DIM_W-1:0]  inv_scale,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] in_addr,
  output logic              in_rd_en,
  input  logic [PIX_W-1:0]  in_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic [PIX_W-1:0]  out_data,
  output logic              out_we,
  input  logic              out_ready
);

  localparam int c_PROD_W = 2 * DIM_W;
  localparam int c_ACC_W  = PIX_W + 2 * FRAC_W + 2;
  localparam logic [FRAC_W:0]    c_ONE  = {1'b1, {FRAC_W{1'b0}}};
  localparam logic [c_ACC_W-1:0] c_HALF = c_ACC_W'(1) << (2 * FRAC_W - 1);
  localparam logic [c_ACC_W-1:0] c_PMAX = c_ACC_W'((1 << PIX_W) - 1);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0, S_COORD = 4'd1, S_RD00 = 4'd2, S_RD10 = 4'd3,
    S_RD01  = 4'd4, S_RD11  = 4'd5, S_WAIT = 4'd6, S_MAC  = 4'd7,
    S_WR    = 4'd8, S_DONE  = 4'd9
  } state_t;

  state_t r_state, w_state_nxt;

  logic [DIM_W-1:0]  r_in_w, r_in_h, r_out_w, r_out_h, r_inv_scale;
  logic [DIM_W-1:0]  r_x_dst, r_y_dst;
  logic [DIM_W-1:0]  r_ix, r_iy, r_ix1, r_iy1;
  logic [FRAC_W-1:0] r_ax, r_ay;
  logic [PIX_W-1:0]  r_i00, r_i10, r_i01, r_i11;

  // Source coordinate and weight generation, clamped at right/bottom edges
  logic [c_PROD_W-1:0] w_xs, w_ys, w_ix_raw, w_iy_raw;
  logic [DIM_W-1:0]    w_xmax, w_ymax, w_ix, w_iy, w_ix1, w_iy1;
  logic [FRAC_W-1:0]   w_ax, w_ay;
  logic                w_x_clamp, w_y_clamp;

  // Coordinate mapping: destination index times reciprocal scale
  always_comb begin
    w_xs      = {{DIM_W{1'b0}}, r_x_dst} * {{DIM_W{1'b0}}, r_inv_scale};
    w_ys      = {{DIM_W{1'b0}}, r_y_dst} * {{DIM_W{1'b0}}, r_inv_scale};
    w_ix_raw  = w_xs >> FRAC_W;
    w_iy_raw  = w_ys >> FRAC_W;
    w_xmax    = r_in_w - DIM_W'(1);
    w_ymax    = r_in_h - DIM_W'(1);
    w_x_clamp = (w_ix_raw >= {{DIM_W{1'b0}}, w_xmax});
    w_y_clamp = (w_iy_raw >= {{DIM_W{1'b0}}, w_ymax});
    w_ix      = w_x_clamp ? w_xmax : w_ix_raw[DIM_W-1:0];
    w_iy      = w_y_clamp ? w_ymax : w_iy_raw[DIM_W-1:0];
    w_ax      = w_x_clamp ? '0 : w_xs[FRAC_W-1:0];
    w_ay      = w_y_clamp ? '0 : w_ys[FRAC_W-1:0];
    w_ix1     = (w_ix < w_xmax) ? w_ix + DIM_W'(1) : w_xmax;
    w_iy1     = (w_iy < w_ymax) ? w_iy + DIM_W'(1) : w_ymax;
  end

  // Weighted blend with round-half-up and saturation to the pixel range
  logic [FRAC_W:0]    w_nax, w_nay;
  logic [c_ACC_W-1:0] w_top, w_bot, w_v, w_q;
  logic [PIX_W-1:0]   w_result;

  // Two-stage horizontal then vertical interpolation
  always_comb begin
    w_nax    = c_ONE - {1'b0, r_ax};
    w_nay    = c_ONE - {1'b0, r_ay};
    w_top    = c_ACC_W'(r_i00) * c_ACC_W'(w_nax) + c_ACC_W'(r_i10) * c_ACC_W'(r_ax);
    w_bot    = c_ACC_W'(r_i01) * c_ACC_W'(w_nax) + c_ACC_W'(r_i11) * c_ACC_W'(r_ax);
    w_v      = w_top * c_ACC_W'(w_nay) + w_bot * c_ACC_W'(r_ay);
    w_q      = (w_v + c_HALF) >> (2 * FRAC_W);
    w_result = (w_q > c_PMAX) ? {PIX_W{1'b1}} : w_q[PIX_W-1:0];
  end

  logic w_x_last, w_y_last;
  assign w_x_last = ((DIM_W+1)'(r_x_dst) + (DIM_W+1)'(1)) >= (DIM_W+1)'(r_out_w);
  assign w_y_last = ((DIM_W+1)'(r_y_dst) + (DIM_W+1)'(1)) >= (DIM_W+1)'(r_out_h);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode and per-state output strobes/addresses
  logic [DIM_W-1:0] w_rd_x, w_rd_y;
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b1;
    done        = 1'b0;
    in_rd_en    = 1'b0;
    out_we      = 1'b0;
    w_rd_x      = r_ix;
    w_rd_y      = r_iy;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          if ((in_w == '0) || (in_h == '0) || (out_w == '0) || (out_h == '0))
            w_state_nxt = S_DONE;
          else
            w_state_nxt = S_COORD;
        end
      end
      S_COORD: w_state_nxt = S_RD00;
      S_RD00: begin
        in_rd_en = 1'b1;
        w_state_nxt = S_RD10;
      end
      S_RD10: begin
        in_rd_en = 1'b1;
        w_rd_x = r_ix1;
        w_state_nxt = S_RD01;
      end
      S_RD01: begin
        in_rd_en = 1'b1;
        w_rd_y = r_iy1;
        w_state_nxt = S_RD11;
      end
      S_RD11: begin
        in_rd_en = 1'b1;
        w_rd_x = r_ix1;
        w_rd_y = r_iy1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: w_state_nxt = S_MAC;
      S_MAC:  w_state_nxt = S_WR;
      S_WR: begin
        // A write still in flight when reset asserts must not reach the sink
        out_we = rst_n;
        if (out_ready)
          w_state_nxt = (w_x_last && w_y_last) ? S_DONE : S_COORD;
      end
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    in_addr  = in_rd_en ? (ADDR_W'(w_rd_y) * ADDR_W'(r_in_w) + ADDR_W'(w_rd_x)) : '0;
    out_addr = (r_state == S_WR) ?
               (ADDR_W'(r_y_dst) * ADDR_W'(r_out_w) + ADDR_W'(r_x_dst)) : '0;
  end

  // Datapath registers: config latch, raster counters, neighbours, result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_in_w <= '0; r_in_h <= '0; r_out_w <= '0; r_out_h <= '0;
      r_inv_scale <= '0;
      r_x_dst <= '0; r_y_dst <= '0;
      r_ix <= '0; r_iy <= '0; r_ix1 <= '0; r_iy1 <= '0;
      r_ax <= '0; r_ay <= '0;
      r_i00 <= '0; r_i10 <= '0; r_i01 <= '0; r_i11 <= '0;
      out_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_in_w <= in_w; r_in_h <= in_h;
          r_out_w <= out_w; r_out_h <= out_h;
          r_inv_scale <= inv_scale;
          r_x_dst <= '0; r_y_dst <= '0;
        end
        S_COORD: begin
          r_ix <= w_ix; r_iy <= w_iy; r_ix1 <= w_ix1; r_iy1 <= w_iy1;
          r_ax <= w_ax; r_ay <= w_ay;
        end
        S_RD10: r_i00 <= in_data;
        S_RD01: r_i10 <= in_data;
        S_RD11: r_i01 <= in_data;
        S_WAIT: r_i11 <= in_data;
        S_MAC:  out_data <= w_result;
        S_WR: if (out_ready) begin
          if (!w_x_last) begin
            r_x_dst <= r_x_dst + DIM_W'(1);
          end else begin
            r_x_dst <= '0;
            if (!w_y_last) r_y_dst <= r_y_dst + DIM_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
